// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter that shares one line-wide memory port
// between the icache (read-only) and the dcache (read/write).
// Only one transaction is in flight. The request is latched at acceptance
// and replayed to memory. The memory response is steered back to the
// requester that holds the grant.
module mem_arbiter #(
    parameter int LINE_BITS = 128,
    parameter int ADDR_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 ic_req_valid_i,
    output logic                 ic_req_ready_o,
    input  logic [ADDR_BITS-1:0] ic_addr_i,
    output logic                 ic_rsp_valid_o,
    input  logic                 ic_rsp_ready_i,
    output logic [LINE_BITS-1:0] ic_rsp_data_o,
    output logic [ADDR_BITS-1:0] ic_rsp_addr_o,
    input  logic                 dc_req_valid_i,
    output logic                 dc_req_ready_o,
    input  logic [ADDR_BITS-1:0] dc_addr_i,
    input  logic                 dc_we_i,
    input  logic [LINE_BITS-1:0] dc_data_wr_i,
    output logic                 dc_rsp_valid_o,
    input  logic                 dc_rsp_ready_i,
    output logic [LINE_BITS-1:0] dc_rsp_data_o,
    output logic [ADDR_BITS-1:0] dc_rsp_addr_o,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [LINE_BITS-1:0] mem_data_wr_o,
    input  logic                 mem_rsp_valid_i,
    output logic                 mem_rsp_ready_o,
    input  logic [LINE_BITS-1:0] mem_data_line_i,
    input  logic [ADDR_BITS-1:0] mem_rsp_addr_i,
    output logic                 err_o
);

    // Byte-offset bits inside a line; these are ignored by the line-address check.
    localparam int OFF_BITS = $clog2(LINE_BITS / 8);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RSP} state_t;

    // Grant encoding: 0 = icache, 1 = dcache.
    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

    state_t                 state_q;
    logic                   grant_q;
    logic                   last_grant_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   we_q;
    logic [LINE_BITS-1:0]   wdata_q;
    logic                   mem_req_valid_q;
    logic                   err_q;

    logic ic_win;
    logic dc_win;
    logic in_idle;
    logic in_rsp;
    logic rsp_to_ic;
    logic rsp_to_dc;
    logic rsp_done;
    logic line_mismatch;
    logic unused_offset_bits;

    // Round-robin winner: on a tie, the side that did not win last time wins.
    assign ic_win = ic_req_valid_i && (!dc_req_valid_i || (last_grant_q == GNT_DC));
    assign dc_win = dc_req_valid_i && !ic_win;

    // Every output is forced low while reset is asserted, whatever the state.
    assign in_idle   = rstn_i && (state_q == ST_IDLE);
    assign in_rsp    = rstn_i && (state_q == ST_RSP);
    assign rsp_to_ic = in_rsp && (grant_q == GNT_IC);
    assign rsp_to_dc = in_rsp && (grant_q == GNT_DC);

    assign ic_req_ready_o = in_idle && ic_win;
    assign dc_req_ready_o = in_idle && dc_win;

    // The response path is combinational, so forwarding adds no cycles.
    assign ic_rsp_valid_o = rsp_to_ic && mem_rsp_valid_i;
    assign ic_rsp_data_o  = rsp_to_ic ? mem_data_line_i : '0;
    assign ic_rsp_addr_o  = rsp_to_ic ? mem_rsp_addr_i  : '0;
    assign dc_rsp_valid_o = rsp_to_dc && mem_rsp_valid_i;
    assign dc_rsp_data_o  = rsp_to_dc ? mem_data_line_i : '0;
    assign dc_rsp_addr_o  = rsp_to_dc ? mem_rsp_addr_i  : '0;

    assign mem_rsp_ready_o = (rsp_to_ic && ic_rsp_ready_i) || (rsp_to_dc && dc_rsp_ready_i);
    assign rsp_done        = mem_rsp_valid_i && mem_rsp_ready_o;

    // The request bus is driven only while a request is being presented, and is zero otherwise.
    assign mem_req_valid_o = rstn_i && mem_req_valid_q;
    assign mem_addr_o      = mem_req_valid_o ? addr_q  : '0;
    assign mem_we_o        = mem_req_valid_o && we_q;
    assign mem_data_wr_o   = mem_req_valid_o ? wdata_q : '0;

    assign err_o = rstn_i && err_q;

    assign line_mismatch      = mem_rsp_addr_i[ADDR_BITS-1:OFF_BITS] != addr_q[ADDR_BITS-1:OFF_BITS];
    assign unused_offset_bits = ^mem_rsp_addr_i[OFF_BITS-1:0];

    // Arbitration FSM: accept and latch in IDLE, present to memory in REQ,
    // and wait for the routed response handshake in RSP.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q         <= ST_IDLE;
            grant_q         <= GNT_IC;
            last_grant_q    <= GNT_DC;
            addr_q          <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            mem_req_valid_q <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_rsp_valid_i) begin
                        err_q <= 1'b1;
                    end
                    if (ic_win || dc_win) begin
                        grant_q         <= dc_win;
                        addr_q          <= dc_win ? dc_addr_i : ic_addr_i;
                        we_q            <= dc_win && dc_we_i;
                        wdata_q         <= dc_win ? dc_data_wr_i : '0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_rsp_valid_i) begin
                        err_q <= 1'b1;
                    end
                    if (mem_req_ready_i) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_done) begin
                        last_grant_q <= grant_q;
                        state_q      <= ST_IDLE;
                        if (line_mismatch) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
